// File: rtl/clb_cluster_pkg.sv
// Shared derivations for the parametrised logic cluster: select width,
// per-element config footprint, config array sizing and field offsets.
package clb_cluster_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Select bits per LUT input: enough to name every input and FF feedback
   function automatic int sel_bits(input int n_in, input int n_fle);
      return clog2(n_in + n_fle);
   endfunction

   // Bits per element: K selects, 2^K truth table, bypass, init
   function automatic int fle_bits(input int k, input int s);
      return k * s + (1 << k) + 2;
   endfunction

   function automatic int cfg_bits(input int n_fle, input int fb);
      return n_fle * fb;
   endfunction

   function automatic int cfg_words(input int bits, input int w);
      return (bits + w - 1) / w;
   endfunction

   // Never let the address bus collapse to zero width
   function automatic int addr_bits(input int words);
      return (clog2(words) < 1) ? 1 : clog2(words);
   endfunction

   // Field offsets relative to the start of an element's config slice
   function automatic int sel_off(input int i, input int s);
      return i * s;
   endfunction

   function automatic int lut_off(input int k, input int s);
      return k * s;
   endfunction

   function automatic int bypass_off(input int k, input int s);
      return k * s + (1 << k);
   endfunction

   function automatic int init_off(input int k, input int s);
      return k * s + (1 << k) + 1;
   endfunction

endpackage

// File: rtl/clb_cluster_param_if.sv
// Configuration bus and user-logic pins of the logic cluster.
interface clb_cluster_param_if
   import clb_cluster_pkg::*;
#(
   parameter int N_IN   = 10,
   parameter int N_FLE  = 4,
   parameter int CFG_W  = 8,
   parameter int CFG_AW = addr_bits(cfg_words(cfg_bits(N_FLE, fle_bits(4, sel_bits(N_IN, N_FLE))), CFG_W))
);
   logic              cfg_mode;
   logic              cfg_we;
   logic [CFG_AW-1:0] cfg_addr;
   logic [CFG_W-1:0]  cfg_wdata;
   logic [CFG_W-1:0]  cfg_rdata;
   logic              cfg_err;
   logic              clb_ce;
   logic [N_IN-1:0]   clb_I;
   logic [N_FLE-1:0]  clb_O;

   modport master (
      output cfg_mode, cfg_we, cfg_addr, cfg_wdata, clb_ce, clb_I,
      input  cfg_rdata, cfg_err, clb_O
   );

   modport slave (
      input  cfg_mode, cfg_we, cfg_addr, cfg_wdata, clb_ce, clb_I,
      output cfg_rdata, cfg_err, clb_O
   );
endinterface

// File: rtl/clb_fle_param.sv
// One logic element: K-input LUT, FF with init preload and clock enable,
// and the bypass mux selecting combinational or registered output.
module clb_fle_param #(
   parameter int K = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_cfg_mode,
   input  logic                i_ce,
   input  logic [K-1:0]        i_lut_in,
   input  logic [(1<<K)-1:0]   i_truth,
   input  logic                i_bypass,
   input  logic                i_init,
   output logic                o_q,
   output logic                o_out
);
   logic r_q;
   logic w_lut;

   assign w_lut = i_truth[i_lut_in];

   // FF preloads init while configuring, otherwise captures the LUT when enabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_q <= 1'b0;
      else if (i_cfg_mode) r_q <= i_init;
      else if (i_ce)       r_q <= w_lut;
   end

   assign o_q   = r_q;
   assign o_out = i_cfg_mode ? 1'b0 : (i_bypass ? w_lut : r_q);
endmodule

// File: rtl/clb_cluster_param.sv
// Parametrised CLB core: flat config array with word bus access, per-LUT-input
// crossbar selects over cluster inputs and FF feedback, N_FLE logic elements.
module clb_cluster_param
   import clb_cluster_pkg::*;
#(
   parameter int N_FLE = 4,
   parameter int K     = 4,
   parameter int N_IN  = 10,
   parameter int CFG_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   clb_cluster_param_if.slave bus
);
   localparam int S         = sel_bits(N_IN, N_FLE);
   localparam int FB        = fle_bits(K, S);
   localparam int CFG_BITS  = cfg_bits(N_FLE, FB);
   localparam int CFG_WORDS = cfg_words(CFG_BITS, CFG_W);
   localparam int CFG_AW    = addr_bits(CFG_WORDS);
   localparam int NSRC      = N_IN + N_FLE;
   localparam int LUT_SZ    = 1 << K;

   logic [CFG_BITS-1:0] r_cfg;
   logic [CFG_W-1:0]    r_rdata;
   logic                r_err;

   logic [CFG_AW-1:0]   w_addr;
   logic                w_addr_ok;
   logic                w_wr_ok;
   logic                w_wr_bad;
   logic [CFG_W-1:0]    w_rd_word;
   logic [N_FLE-1:0]    w_q;
   logic [N_FLE-1:0]    w_out;
   logic [NSRC-1:0]     w_src;

   assign w_addr    = bus.cfg_addr;
   assign w_addr_ok = int'(w_addr) < CFG_WORDS;
   assign w_wr_ok   = bus.cfg_we & bus.cfg_mode & w_addr_ok;
   assign w_wr_bad  = bus.cfg_we & (~bus.cfg_mode | ~w_addr_ok);

   // Word write into the flat array; pad bits past CFG_BITS have no storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cfg <= '0;
      end else if (w_wr_ok) begin
         for (int j = 0; j < CFG_W; j++) begin
            if (int'(w_addr) * CFG_W + j < CFG_BITS)
               r_cfg[int'(w_addr) * CFG_W + j] <= bus.cfg_wdata[j];
         end
      end
   end

   // Readback mux: out-of-range words and pad bits read as zero
   always_comb begin
      w_rd_word = '0;
      if (w_addr_ok) begin
         for (int j = 0; j < CFG_W; j++) begin
            if (int'(w_addr) * CFG_W + j < CFG_BITS)
               w_rd_word[j] = r_cfg[int'(w_addr) * CFG_W + j];
         end
      end
   end

   // Registered readback (pre-write value on same-cycle access) and sticky error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_rdata <= w_rd_word;
         if (w_wr_bad) r_err <= 1'b1;
      end
   end

   // Feedback comes only from FF q, so the crossbar cannot form a loop
   assign w_src = {w_q, bus.clb_I};

   genvar e, i;
   generate
      for (e = 0; e < N_FLE; e++) begin : g_fle
         logic [K-1:0] w_lut_in;

         for (i = 0; i < K; i++) begin : g_sel
            logic [S-1:0] w_sel;
            logic         w_bit;

            assign w_sel = r_cfg[e*FB + sel_off(i, S) +: S];

            // Select decode: cluster input, FF feedback, or constant 0 beyond range
            always_comb begin
               w_bit = 1'b0;
               for (int v = 0; v < NSRC; v++) begin
                  if (int'(w_sel) == v) w_bit = w_src[v];
               end
            end

            assign w_lut_in[i] = w_bit;
         end

         clb_fle_param #(.K(K)) u_fle (
            .clk        (clk),
            .reset      (reset),
            .i_cfg_mode (bus.cfg_mode),
            .i_ce       (bus.clb_ce),
            .i_lut_in   (w_lut_in),
            .i_truth    (r_cfg[e*FB + lut_off(K, S) +: LUT_SZ]),
            .i_bypass   (r_cfg[e*FB + bypass_off(K, S)]),
            .i_init     (r_cfg[e*FB + init_off(K, S)]),
            .o_q        (w_q[e]),
            .o_out      (w_out[e])
         );
      end
   endgenerate

   assign bus.clb_O     = w_out;
   assign bus.cfg_rdata = r_rdata;
   assign bus.cfg_err   = r_err;
endmodule

// File: tb/tb_clb_cluster_param.sv
// Directed bench for clb_cluster_param with a bit-level behavioural model.
module tb_clb_cluster_param;
   localparam int NF = 4;
   localparam int K  = 4;
   localparam int NI = 10;
   localparam int W  = 8;
   localparam int S  = 4;
   localparam int FB = K * S + (1 << K) + 2;
   localparam int NB = NF * FB;
   localparam int NW = (NB + W - 1) / W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   clb_cluster_param_if #(.N_IN(NI), .N_FLE(NF), .CFG_W(W), .CFG_AW(5)) bus ();

   clb_cluster_param #(.N_FLE(NF), .K(K), .N_IN(NI), .CFG_W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [NB-1:0] m_cfg;
   logic [NF-1:0] m_q;
   logic [W-1:0]  m_rdata;
   logic          m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] m_word(input int a);
      logic [W-1:0] r;
      r = '0;
      if (a < NW)
         for (int j = 0; j < W; j++)
            if (a * W + j < NB) r[j] = m_cfg[a * W + j];
      return r;
   endfunction

   function automatic logic m_lut(input int e);
      logic [K-1:0] idx;
      logic [S-1:0] v;
      int           iv;
      for (int i = 0; i < K; i++) begin
         v  = m_cfg[e * FB + i * S +: S];
         iv = int'(v);
         if (iv < NI)           idx[i] = bus.clb_I[iv];
         else if (iv < NI + NF) idx[i] = m_q[iv - NI];
         else                   idx[i] = 1'b0;
      end
      return m_cfg[e * FB + K * S + int'(idx)];
   endfunction

   function automatic logic [NF-1:0] m_out();
      logic [NF-1:0] o;
      o = '0;
      if (!bus.cfg_mode)
         for (int e = 0; e < NF; e++)
            o[e] = m_cfg[e * FB + K * S + (1 << K)] ? m_lut(e) : m_q[e];
      return o;
   endfunction

   task automatic m_clear();
      m_cfg   = '0;
      m_q     = '0;
      m_rdata = '0;
      m_err   = 1'b0;
   endtask

   // One clock edge: model next state from pre-edge inputs, commit 1 ns after edge
   task automatic tick();
      logic [NF-1:0] nq;
      logic [W-1:0]  nr;
      logic          ne;
      logic [NB-1:0] nc;
      int            a;
      if (reset) begin
         @(posedge clk);
         #1;
         return;
      end
      for (int e = 0; e < NF; e++)
         nq[e] = bus.cfg_mode ? m_cfg[e * FB + K * S + (1 << K) + 1]
               : (bus.clb_ce ? m_lut(e) : m_q[e]);
      a  = int'(bus.cfg_addr);
      nr = m_word(a);
      ne = m_err | (bus.cfg_we & (~bus.cfg_mode | (a >= NW)));
      nc = m_cfg;
      if (bus.cfg_we && bus.cfg_mode && a < NW)
         for (int j = 0; j < W; j++)
            if (a * W + j < NB) nc[a * W + j] = bus.cfg_wdata[j];
      @(posedge clk);
      #1;
      m_q = nq; m_rdata = nr; m_err = ne; m_cfg = nc;
   endtask

   task automatic wr(input int a, input logic [W-1:0] d);
      logic [31:0] av;
      av = a;
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = av[4:0];
      bus.cfg_wdata = d;
      tick();
      bus.cfg_we    = 1'b0;
   endtask

   task automatic rd(input int a, output logic [W-1:0] d);
      logic [31:0] av;
      av = a;
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = av[4:0];
      tick();
      d = bus.cfg_rdata;
   endtask

   // Every cycle: DUT outputs against the model
   always @(negedge clk) begin
      chk("clb_O", 32'(bus.clb_O), 32'(m_out()));
      chk("cfg_rdata", 32'(bus.cfg_rdata), 32'(m_rdata));
      chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
   end

   logic [NB-1:0] img;
   logic [W-1:0]  d;

   initial begin
      reset = 1'b1;
      bus.cfg_mode = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = '0;
      bus.cfg_wdata = '0;  bus.clb_ce = 1'b0; bus.clb_I = '0;
      m_clear();
      tick(); tick();
      reset = 1'b0;

      // Reset state
      for (int a = 0; a < NW; a++) begin
         rd(a, d);
         chk("rst_rd", 32'(d), 32'h0);
      end
      chk("rst_O", 32'(bus.clb_O), 32'h0);
      chk("rst_err", 32'(bus.cfg_err), 32'h0);

      // Element 0: AND of clb_I[1:0], bypass; element 1: toggle FF with init=1
      img = '0;
      img[3:0]   = 4'd0;  img[7:4]   = 4'd1;
      img[11:8]  = 4'd15; img[15:12] = 4'd15;
      img[19]    = 1'b1;  img[32]    = 1'b1;
      img[37:34] = 4'd11; img[41:38] = 4'd15;
      img[45:42] = 4'd15; img[49:46] = 4'd15;
      img[50]    = 1'b1;  img[67]    = 1'b1;
      for (int a = 0; a < NW; a++) wr(a, img[a * W +: W]);
      rd(0, d); chk("rb_w0", 32'(d), 32'h10);
      rd(1, d); chk("rb_w1", 32'(d), 32'hFF);
      rd(2, d); chk("rb_w2", 32'(d), 32'h08);
      rd(4, d); chk("rb_w4", 32'(d), 32'hED);
      rd(6, d); chk("rb_w6", 32'(d), 32'h07);
      rd(8, d); chk("rb_w8", 32'(d), 32'h08);
      chk("cfgmode_O", 32'(bus.clb_O), 32'h0);

      // User mode, combinational AND path
      bus.cfg_mode = 1'b0; bus.clb_ce = 1'b0;
      bus.clb_I = 10'b11; #1;
      chk("and11", 32'(bus.clb_O), 32'h3);
      bus.clb_I = 10'b01; #1;
      chk("and01", 32'(bus.clb_O), 32'h2);
      bus.clb_I = 10'b10; #1;
      chk("and10", 32'(bus.clb_O[0]), 32'h0);

      // Toggle: 1,0,1,0 with ce, then hold
      bus.clb_ce = 1'b1;
      chk("tog0", 32'(bus.clb_O[1]), 32'h1);
      tick(); chk("tog1", 32'(bus.clb_O[1]), 32'h0);
      tick(); chk("tog2", 32'(bus.clb_O[1]), 32'h1);
      tick(); chk("tog3", 32'(bus.clb_O[1]), 32'h0);
      bus.clb_ce = 1'b0;
      tick(); chk("hold1", 32'(bus.clb_O[1]), 32'h0);
      tick(); chk("hold2", 32'(bus.clb_O[1]), 32'h0);

      // Write in user mode is dropped and flags an error
      wr(3, 8'hA5);
      chk("um_err", 32'(bus.cfg_err), 32'h1);
      rd(3, d); chk("um_w3", 32'(d), 32'h00);

      // Reset in the middle of toggling
      bus.clb_ce = 1'b1;
      tick(); tick(); tick();
      chk("pre_rst", 32'(bus.clb_O[1]), 32'h1);
      #2;
      reset = 1'b1;
      m_clear();
      #1;
      chk("mid_rst_O", 32'(bus.clb_O), 32'h0);
      chk("mid_rst_err", 32'(bus.cfg_err), 32'h0);
      tick();
      reset = 1'b0;
      bus.clb_I = '1;
      #1;
      chk("post_rst_O", 32'(bus.clb_O), 32'h0);
      bus.clb_ce = 1'b0;
      for (int a = 0; a < NW; a++) begin
         rd(a, d);
         chk("post_rst_rd", 32'(d), 32'h0);
      end

      // Out-of-range write in configuration mode
      bus.cfg_mode = 1'b1;
      wr(20, 8'h5A);
      chk("oor_err", 32'(bus.cfg_err), 32'h1);
      for (int a = 0; a < NW; a++) begin
         rd(a, d);
         chk("oor_rd", 32'(d), 32'h0);
      end
      rd(20, d); chk("oor_rd20", 32'(d), 32'h0);

      // Same-cycle write and read returns the old word
      wr(5, 8'h3C);
      chk("wr_rd_old", 32'(bus.cfg_rdata), 32'h00);
      rd(5, d); chk("wr_rd_new", 32'(d), 32'h3C);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/clb_cluster_param.md
# clb_cluster_param

Parametrised logic cluster: N fracturable-free logic elements (K-input LUT + FF), each LUT input fed by a full-crossbar select over cluster inputs and FF feedback. All configuration lives in one word-addressable register array written and read back over a simple bus. Writes are only accepted in configuration mode, and FFs preload from a per-element init bit. It replaces the fixed 4-FLE/4-LUT/10-input cluster as the CLB tile core of the fabric generator output.

## Interface
- N_FLE, 4, number of logic elements
- K, 4, LUT inputs per element
- N_IN, 10, cluster inputs
- CFG_W, 8, configuration bus word width
- Derived: S = clog2(N_IN+N_FLE) select bits per LUT input; FB = K*S + 2^K + 2 bits per element; CFG_BITS = N_FLE*FB; CFG_WORDS = ceil(CFG_BITS/CFG_W); CFG_AW = clog2(CFG_WORDS)
- Defaults give S=4, FB=34, CFG_BITS=136, CFG_WORDS=17, CFG_AW=5

Ports:
- clk  input  1  single clock for configuration and user logic
- reset  input  1  asynchronous, active-high
- cfg_mode  input  1  1 = configuration mode, 0 = user mode
- cfg_we  input  1  write strobe
- cfg_addr  input  CFG_AW  word address
- cfg_wdata  input  CFG_W  write data
- cfg_rdata  output  CFG_W  registered readback
- cfg_err  output  1  sticky error flag
- clb_ce  input  1  user-mode FF clock enable
- clb_I  input  N_IN  cluster inputs
- clb_O  output  N_FLE  element outputs

## Operation
- Config array is flat. Element e occupies bits [e*FB +: FB], ordered LSB-first as follows:
  - K select fields of S bits, input 0 first
  - LUT truth table, 2^K bits; bit i is the output for LUT input value i
  - bypass bit: 1 = combinational output
  - init bit
- Word a maps to bits [a*CFG_W +: CFG_W]. Pad bits in the last word read 0 and ignore writes.
- Select decode:
  - v < N_IN → clb_I[v]
  - N_IN ≤ v < N_IN+N_FLE → FF q of element v-N_IN
  - v ≥ N_IN+N_FLE → constant 0
- Feedback is taken only from FF q, so no combinational loop is possible.
- clb_O[e] = bypass ? lut_out : q. In cfg_mode, clb_O is forced to all zeros.
- FF behaviour:
  - In cfg_mode, q loads the init bit every cycle.
  - In user mode, q <= lut_out when clb_ce=1; otherwise it holds.
- Write accepted when cfg_we=1, cfg_mode=1 and cfg_addr < CFG_WORDS.
- cfg_err is set (sticky) by either of:
  - cfg_we=1 with cfg_mode=0 (the write is dropped)
  - cfg_we=1 with an out-of-range address (the write is dropped)
- Readback is always enabled. Out-of-range addresses return 0.
- Reset clears all config bits, all q, cfg_rdata and cfg_err to 0.

## Timing
- A write at edge t is visible in LUT/select behaviour and in readback from t+1.
- cfg_rdata = word[cfg_addr] sampled at edge t, valid after t (1-cycle latency).
- Write and read of the same address in the same cycle returns the pre-write value.
- cfg_mode 1→0 at edge t: q holds its init value after t. The first user-mode update is at edge t+1 if clb_ce=1.
- cfg_mode 0→1: q loads init at the next edge, and clb_O goes 0 combinationally.
- Path clb_I → clb_O is combinational when bypass=1. The registered path has 1 cycle latency.
- Reset asserted mid-operation clears everything asynchronously. After deassertion the array is all-zero: every select is 0, every LUT is 0, and clb_O = 0.

## Structure
- clb_cluster_pkg holds the clog2 function, the S/FB/CFG_BITS/CFG_WORDS derivation functions, and the field-offset functions (sel_off, lut_off, bypass_off, init_off).
- Sub-module clb_fle_param contains the K-input LUT, FF with init load and ce, and output bypass mux. It is instantiated N_FLE times.
- Select muxes and the config array live in the top level.

## Test plan
- Reset, then read all 17 words → every read returns 0x00; clb_O=0; cfg_err=0.
- Configure element 0:
  - Setup: sel0=clb_I[0], sel1=clb_I[1], LUT=AND (bit 3 set, upper inputs tied via sel=15→0), bypass=1, then cfg_mode=0.
  - Stimulus/response: clb_I[1:0]=11 → clb_O[0]=1; clb_I[1:0]=01 → clb_O[0]=0, same cycle.
- Element 1 as toggle FF:
  - Setup: sel0 = own q (select 11), LUT = NOT input 0, init=1, bypass=0.
  - Stimulus/response: leave cfg_mode → clb_O[1] = 1,0,1,0 on successive edges with clb_ce=1; it holds while clb_ce=0.
- Write word 3 = 0xA5 in user mode → cfg_err=1 and word 3 is unchanged on readback.
- Write to address 20 in cfg_mode → cfg_err=1 and no word changes.
- Assert reset during a toggle sequence → clb_O=0 immediately; config readback is all 0 after release.
